melody_sequencer: RTL and testbench
===================================

MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25000000: clk cycles per tempo tick, legal range >= 2.
REQ-002 SHALL have parameter LAST_ADDR, default 148: final note-ROM address of the melody.
REQ-003 SHALL have parameter AW, default 8: address width; LAST_ADDR < 2**AW.
REQ-004 SHALL have port clk, input, 1: single system clock; all logic on posedge clk.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port play, input, 1: start from IDLE/DONE, or resume from PAUSE; level-sampled each cycle.
REQ-007 SHALL have port pause, input, 1: freeze playback while in PLAY.
REQ-008 SHALL have port stop, input, 1: abort to IDLE from any state.
REQ-009 SHALL have port loop, input, 1: when 1, wrap from LAST_ADDR to 0 instead of finishing.
REQ-010 SHALL have port dur_in, input, 4: note duration in ticks, read from the note ROM at addr.
REQ-011 SHALL have port addr, output, AW: note-ROM address currently playing.
REQ-012 SHALL have port note_en, output, 1: 1 only in PLAY; gates the tone generator.
REQ-013 SHALL have port busy, output, 1: 1 in PLAY or PAUSE.
REQ-014 SHALL have port done, output, 1: one-cycle pulse when the melody ends.
REQ-015 SHALL have port state, output, 2: IDLE=0, PLAY=1, PAUSE=2, DONE=3.

Function
REQ-016 SHALL implement FSM states IDLE, PLAY, PAUSE, DONE; command priority stop > pause > play.
REQ-017 SHALL on stop in any state, next cycle: state IDLE, addr 0, tick and duration counters cleared.
REQ-018 SHALL on play in IDLE or DONE, next cycle: state PLAY, addr 0, tick counter 0, load pending set.
REQ-019 SHALL in PLAY with pause=1 go to PAUSE next cycle; play and pause together in PLAY: pause wins.
REQ-020 SHALL in PAUSE with play=1 and pause=0 return to PLAY next cycle, continuing the frozen addr, tick and duration counts.
REQ-021 SHALL in PAUSE hold addr, tick counter and duration counter unchanged.
REQ-022 SHALL run the tick counter 0..TICK_DIV-1 only in PLAY; tick asserts for one cycle when the count equals TICK_DIV-1, then the count wraps to 0.
REQ-023 SHALL sample dur_in one cycle after every addr update (load pending flag), supporting a 1-cycle synchronous ROM; dur_in=0 is treated as 1.
REQ-024 SHALL on each tick in PLAY decrement the duration counter when it is greater than 1, else advance the note.
REQ-025 SHALL on advance with addr<LAST_ADDR set addr <= addr+1 and set load pending.
REQ-026 SHALL on advance with addr==LAST_ADDR and loop=1 set addr <= 0 and set load pending, with no done pulse.
REQ-027 SHALL on advance with addr==LAST_ADDR and loop=0 go to DONE, hold addr at LAST_ADDR, and pulse done for one cycle.
REQ-028 SHALL never drive addr above LAST_ADDR, under any input sequence.
REQ-029 SHALL hold DONE until play (restart) or stop (to IDLE).
REQ-030 SHALL ignore pause outside PLAY and play while in PLAY.
REQ-031 SHALL drive note_en and busy combinationally from state; done is registered.

Reset
REQ-032 SHALL on reset=1 immediately force state IDLE, addr 0, note_en 0, busy 0, done 0, and all counters 0, regardless of clk.
REQ-033 SHALL on reset asserted mid-PLAY abandon playback; after release, remain in IDLE until play.

Verification
REQ-034 SHALL verify, with TICK_DIV=4, LAST_ADDR=3, dur_in=1 and one play pulse, addr 0,1,2,3 each held 4 cycles, then state=3 and done high exactly 1 cycle.
REQ-035 SHALL verify, with dur_in=3 at addr 1 (others 1), that addr=1 is held 12 cycles.
REQ-036 SHALL verify, with loop=1, that addr goes 3 -> 0 with no done pulse and busy stays 1.
REQ-037 SHALL verify pause at addr 2 held 10 cycles then play: addr, tick and duration counts frozen, and the remaining time at addr 2 equals the time left before the pause.
REQ-038 SHALL verify stop and play asserted together in PLAY -> IDLE, addr 0; play alone in DONE -> restart at addr 0.
REQ-039 SHALL verify reset pulsed between clk edges mid-PLAY -> outputs zero before the next edge, state 0.

Source files
------------

// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - tempo-ticked note sequencer walking a duration ROM
//
// Purpose:
//   Steps a note-ROM address from 0 to LAST_ADDR. Every note is held for
//   max(dur_in,1) tempo ticks, and a tempo tick is TICK_DIV clk cycles of
//   PLAY. Playback can be paused and resumed, stopped, or looped. Without
//   loop it ends in DONE with a one-cycle done pulse.
//
// Parameters:
//   TICK_DIV  - clk cycles per tempo tick (>= 2)
//   LAST_ADDR - final note-ROM address of the melody
//   AW        - address width (LAST_ADDR < 2**AW)
//
// Ports:
//   clk     in   system clock, all logic on its rising edge
//   reset   in   asynchronous active-high reset
//   play    in   start from IDLE/DONE, resume from PAUSE
//   pause   in   freeze playback while in PLAY
//   stop    in   abort to IDLE from any state (highest priority)
//   loop    in   wrap LAST_ADDR -> 0 instead of finishing
//   dur_in  in   note duration in ticks, read from the ROM at addr
//   addr    out  note-ROM address currently playing
//   note_en out  high only in PLAY, gates the tone generator
//   busy    out  high in PLAY or PAUSE
//   done    out  registered one-cycle pulse at end of melody
//   state   out  IDLE=0, PLAY=1, PAUSE=2, DONE=3

module melody_sequencer #(
  parameter int TICK_DIV  = 25000000,
  parameter int LAST_ADDR = 148,
  parameter int AW        = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          play,
  input  logic          pause,
  input  logic          stop,
  input  logic          loop,
  input  logic [3:0]    dur_in,
  output logic [AW-1:0] addr,
  output logic          note_en,
  output logic          busy,
  output logic          done,
  output logic [1:0]    state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PLAY  = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int            TW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [AW-1:0] LAST_A   = AW'(LAST_ADDR);

  logic [1:0]    state_r;
  logic [AW-1:0] addr_r;
  logic [TW-1:0] tick_cnt;
  logic [3:0]    dur_cnt;
  logic          load_pend;
  logic          done_r;

  logic tick;
  logic advance;
  logic finish;

  // The tick counter only runs in PLAY, so a tick can only occur there.
  assign tick = (state_r == S_PLAY) && (tick_cnt == TICK_MAX);

  // A note ends on a tick once its duration has counted down to 1. The
  // duration load always happens on a tick count of 0. Every addr update
  // restarts the tick count at 0, and TICK_DIV >= 2. Together these mean
  // a pending load never coincides with a tick.
  assign advance = tick && !load_pend && (dur_cnt <= 4'd1);

  // Reaching the last note without loop ends the melody. This takes
  // precedence over a simultaneous pause, so the done pulse is never lost.
  assign finish = advance && (addr_r >= LAST_A) && !loop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= S_IDLE;
      addr_r    <= '0;
      tick_cnt  <= '0;
      dur_cnt   <= 4'd0;
      load_pend <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (stop) begin
        state_r   <= S_IDLE;
        addr_r    <= '0;
        tick_cnt  <= '0;
        dur_cnt   <= 4'd0;
        load_pend <= 1'b0;
      end else begin
        case (state_r)
          S_IDLE, S_DONE: begin
            if (play) begin
              state_r   <= S_PLAY;
              addr_r    <= '0;
              tick_cnt  <= '0;
              dur_cnt   <= 4'd0;
              load_pend <= 1'b1;
            end
          end

          S_PLAY: begin
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);

            // The ROM answers one cycle after addr changes, so the duration
            // is captured on the first PLAY cycle after each address update.
            if (load_pend) begin
              dur_cnt   <= (dur_in == 4'd0) ? 4'd1 : dur_in;
              load_pend <= 1'b0;
            end else if (tick) begin
              if (dur_cnt > 4'd1) begin
                dur_cnt <= dur_cnt - 4'd1;
              end else if (addr_r < LAST_A) begin
                addr_r    <= addr_r + AW'(1);
                load_pend <= 1'b1;
              end else if (loop) begin
                addr_r    <= '0;
                load_pend <= 1'b1;
              end else begin
                // addr stays at LAST_A while the sequencer sits in DONE.
                state_r <= S_DONE;
                done_r  <= 1'b1;
              end
            end

            // The current PLAY cycle still counts. Pause only stops counting
            // from the next cycle on, and play is ignored here.
            if (pause && !finish) begin
              state_r <= S_PAUSE;
            end
          end

          S_PAUSE: begin
            // Counters and load_pend are frozen, so playback resumes mid-note.
            if (play && !pause) begin
              state_r <= S_PLAY;
            end
          end
        endcase
      end
    end
  end

  assign addr    = addr_r;
  assign state   = state_r;
  assign done    = done_r;
  assign note_en = (state_r == S_PLAY);
  assign busy    = (state_r == S_PLAY) || (state_r == S_PAUSE);

endmodule

// File: tb/tb_melody_sequencer.sv
// tb/tb_melody_sequencer.sv - randomized scoreboard bench for melody_sequencer
module tb_melody_sequencer;

  localparam int TD = 4;
  localparam int LA = 3;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          play, pause, stop, loop;
  logic [3:0]    dur_in;
  logic [AW-1:0] addr;
  logic          note_en, busy, done;
  logic [1:0]    state;

  melody_sequencer #(.TICK_DIV(TD), .LAST_ADDR(LA), .AW(AW)) dut (
    .clk(clk), .reset(reset), .play(play), .pause(pause), .stop(stop),
    .loop(loop), .dur_in(dur_in), .addr(addr), .note_en(note_en),
    .busy(busy), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  logic [3:0] rom [0:LA];
  always_comb dur_in = (addr <= AW'(LA)) ? rom[addr[1:0]] : 4'd0;

  typedef struct packed {
    logic [1:0]    st;
    logic [AW-1:0] a;
    logic          ne;
    logic          bz;
    logic          dn;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   hold_cnt [0:LA];
  int   done_cnt;
  int   busy_low;

  // Reference model: note position plus PLAY cycles left on the current note.
  int m_state, m_addr, m_rem;

  function automatic int note_cycles(input int a);
    int d;
    d = int'(rom[a]);
    return TD * ((d == 0) ? 1 : d);
  endfunction

  task automatic model_reset();
    m_state = 0; m_addr = 0; m_rem = 0;
  endtask

  task automatic model_step(input bit p, input bit pa, input bit s, input bit l);
    bit   dn;
    exp_t e;
    dn = 1'b0;
    if (s) begin
      m_state = 0; m_addr = 0;
    end else begin
      case (m_state)
        0, 3: if (p) begin m_state = 1; m_addr = 0; m_rem = note_cycles(0); end
        1: begin
          m_rem--;
          if (m_rem == 0) begin
            if (m_addr < LA) begin m_addr++; m_rem = note_cycles(m_addr); end
            else if (l) begin m_addr = 0; m_rem = note_cycles(0); end
            else begin m_state = 3; dn = 1'b1; end
          end
          if (m_state == 1 && pa) m_state = 2;
        end
        2: if (p && !pa) m_state = 1;
        default: m_state = 0;
      endcase
    end
    e.st = 2'(m_state);
    e.a  = AW'(m_addr);
    e.ne = (m_state == 1);
    e.bz = (m_state == 1) || (m_state == 2);
    e.dn = dn;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, expv);
    end
  endtask

  task automatic clear_stats();
    for (int i = 0; i <= LA; i++) hold_cnt[i] = 0;
    done_cnt = 0;
    busy_low = 0;
  endtask

  // Driver step: called at a negedge, applies inputs for one clock.
  task automatic cycle(input bit p, input bit pa, input bit s, input bit l);
    play = p; pause = pa; stop = s; loop = l;
    model_step(p, pa, s, l);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit l);
    repeat (n) cycle(1'b0, 1'b0, 1'b0, l);
  endtask

  // Monitor: compares every clocked output against the scoreboard.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({state, addr, note_en, busy, done} !== e) begin
        errors++;
        $display("FAIL sb t=%0t got st=%0d addr=%0d ne=%0b busy=%0b done=%0b expected st=%0d addr=%0d ne=%0b busy=%0b done=%0b",
                 $time, state, addr, note_en, busy, done, e.st, e.a, e.ne, e.bz, e.dn);
      end
      if (note_en && addr <= AW'(LA)) hold_cnt[addr[1:0]]++;
      if (done) done_cnt++;
      if (!busy) busy_low++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired, bench did not reach its end");
    $fatal(1);
  end

  initial begin
    bit rl;
    reset = 1'b1; play = 1'b0; pause = 1'b0; stop = 1'b0; loop = 1'b0;
    for (int i = 0; i <= LA; i++) rom[i] = 4'd1;
    clear_stats();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset_state", int'(state), 0);
    chk("reset_addr", int'(addr), 0);
    chk("reset_note_en", int'(note_en), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    reset = 1'b0;

    // Plain playback, every note one tick long.
    clear_stats();
    cycle(1, 0, 0, 0);
    run(20, 0);
    for (int i = 0; i <= LA; i++) chk($sformatf("hold_addr%0d", i), hold_cnt[i], TD);
    chk("single_done_pulse", done_cnt, 1);
    chk("done_state", int'(state), 3);

    // Three-tick note at addr 1.
    cycle(0, 0, 1, 0);
    rom[1] = 4'd3;
    clear_stats();
    cycle(1, 0, 0, 0);
    run(40, 0);
    chk("long_note_hold", hold_cnt[1], 3 * TD);

    // Looping: wraps without a done pulse and stays busy.
    cycle(0, 0, 1, 0);
    for (int i = 0; i <= LA; i++) rom[i] = 4'd1;
    cycle(1, 0, 0, 1);
    clear_stats();
    run(30, 1);
    chk("loop_no_done", done_cnt, 0);
    chk("loop_busy_kept", busy_low, 0);

    // Pause part-way through addr 2, hold 10 cycles, resume.
    cycle(0, 0, 1, 0);
    for (int i = 0; i <= LA; i++) rom[i] = 4'd2;
    clear_stats();
    cycle(1, 0, 0, 0);
    run(19, 0);
    cycle(0, 1, 0, 0);
    repeat (10) cycle(0, 1, 0, 0);
    chk("pause_state", int'(state), 2);
    chk("pause_addr", int'(addr), 2);
    cycle(1, 0, 0, 0);
    run(30, 0);
    chk("pause_note_time", hold_cnt[2], 2 * TD);

    // Stop with play in PLAY, then restart from DONE.
    cycle(1, 0, 0, 0);
    run(5, 0);
    cycle(1, 0, 1, 0);
    chk("stop_play_state", int'(state), 0);
    chk("stop_play_addr", int'(addr), 0);
    cycle(1, 0, 0, 0);
    run(40, 0);
    cycle(1, 0, 0, 0);
    chk("restart_addr", int'(addr), 0);
    chk("restart_state", int'(state), 1);
    run(6, 0);

    // Asynchronous reset between edges mid-PLAY.
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_state", int'(state), 0);
    chk("async_rst_outs", int'({addr, note_en, busy, done}), 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    run(5, 0);
    cycle(1, 0, 0, 0);
    run(8, 0);

    // Randomized commands over random durations.
    cycle(0, 0, 1, 0);
    for (int i = 0; i <= LA; i++) rom[i] = 4'($urandom_range(0, 15));
    rl = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 3) rl = ~rl;
      cycle($urandom_range(0, 99) < 8, $urandom_range(0, 99) < 4,
            $urandom_range(0, 199) < 2, rl);
    end

    @(posedge clk);
    #2;
    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
